// File: rtl/hamming_secded_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_pipe_if
//  Description : Streaming bus for the Hamming SEC-DED codec. The input side
//                carries a per-word mode bit (0 = encode, 1 = decode) with the
//                word. The output side carries the result and its error flags.
//  Ports       : mode, in_valid, in_ready, in_data[N]      (input stream)
//                out_valid, out_ready, out_data[N],
//                err_single, err_double                   (output stream)
//  Modports    : master - stream producer/consumer (testbench, upstream logic)
//                slave  - the codec
//  Revision    : 1.0 - initial release
// ============================================================================
interface hamming_secded_pipe_if #(
  parameter int N = 8
);
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         err_single;
  logic         err_double;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_single, err_double
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, err_single, err_double
  );
endinterface
`default_nettype wire

// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_pipe
//  Description : Two-stage pipelined Hamming SEC-DED encoder/decoder with
//                valid/ready backpressure and saturating error counters.
//                Codeword layout: Hamming position p (1..K+R) lives in bit
//                p-1, parity at positions 2^l, data in the remaining
//                positions in ascending order, overall parity in bit N-1.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous, active-high
//                bus       - streaming interface (slave side)
//                clr_cnt   - synchronous clear of both counters
//                corr_cnt  - saturating count of corrected single errors
//                dbl_cnt   - saturating count of uncorrectable errors
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_pipe #(
  parameter int K = 4,
  parameter int R = 3
) (
  input  wire logic              clk,
  input  wire logic              reset,
  hamming_secded_pipe_if.slave   bus,
  input  wire logic              clr_cnt,
  output logic [15:0]            corr_cnt,
  output logic [15:0]            dbl_cnt
);

  localparam int N    = K + R + 1;
  localparam int LAST = K + R;     // highest Hamming position

  generate
    if ((K < 1) || ((1 << R) < (K + R + 1))) begin : g_bad_params
      $error("hamming_secded_pipe: K/R do not form a valid Hamming code");
    end
  endgenerate

  // Hamming position (1-based) holding data bit j.
  function automatic int dpos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= LAST; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Stage 1 registers
  logic         r1_valid;
  logic         r1_mode;
  logic [N-1:0] r1_word;    // encoded codeword (encode) or raw codeword (decode)
  logic [R-1:0] r1_syn;
  logic         r1_par;

  // Stage 2 registers
  logic         r2_valid;
  logic [N-1:0] r_out_data;
  logic         r_err_single;
  logic         r_err_double;

  logic [N-1:0] w_enc_word;
  logic [R-1:0] w_syn;
  logic         w_par;
  logic [N-1:0] w_result;
  logic         w_single;
  logic         w_double;
  logic         w_stall;
  logic         w_s1_en;
  logic         w_out_hs;

  assign w_stall  = r2_valid & ~bus.out_ready;
  // Stage 1 may load whenever it is empty or stage 2 will take its word.
  assign w_s1_en  = ~(w_stall & r1_valid);
  assign w_out_hs = r2_valid & bus.out_ready;

  assign bus.in_ready   = w_s1_en;
  assign bus.out_valid  = r2_valid;
  assign bus.out_data   = r_out_data;
  assign bus.err_single = r_err_single;
  assign bus.err_double = r_err_double;

  // Stage 1 combinational: full encode of in_data[K-1:0], plus syndrome and
  // overall parity of in_data taken as a codeword. Mode picks which is used.
  always_comb begin : p_stage1_comb
    logic [N-1:0] code;
    logic         acc;
    logic [R-1:0] syn;
    logic [31:0]  pos;
    code = '0;
    acc  = 1'b0;
    syn  = '0;
    pos  = '0;
    for (int j = 0; j < K; j++) begin
      code[dpos(j) - 1] = bus.in_data[j];
    end
    for (int l = 0; l < R; l++) begin
      if ((1 << l) <= LAST) begin
        acc = 1'b0;
        for (int p = 1; p <= LAST; p++) begin
          if (p[l] && (p != (1 << l))) acc = acc ^ code[p - 1];
        end
        code[(1 << l) - 1] = acc;
      end
    end
    code[N-1] = ^code[N-2:0];
    for (int p = 1; p <= LAST; p++) begin
      pos = p;
      if (bus.in_data[p - 1]) syn = syn ^ pos[R-1:0];
    end
    w_enc_word = code;
    w_syn      = syn;
    w_par      = ^bus.in_data;
  end

  // Stage 2 combinational: classify S/P, correct, extract data.
  always_comb begin : p_stage2_comb
    logic [N-1:0] fixed;
    logic [31:0]  syn;
    fixed    = r1_word;
    syn      = 32'(r1_syn);
    w_single = 1'b0;
    w_double = 1'b0;
    w_result = '0;
    if (r1_par) begin
      if (syn <= LAST) begin
        // syn == 0 means the overall-parity bit itself flipped
        w_single = 1'b1;
        for (int p = 1; p <= LAST; p++) begin
          if (syn == p) fixed[p - 1] = ~fixed[p - 1];
        end
      end else begin
        w_double = 1'b1;
      end
    end else if (syn != 0) begin
      w_double = 1'b1;
    end
    for (int j = 0; j < K; j++) begin
      w_result[j] = fixed[dpos(j) - 1];
    end
    if (!r1_mode) begin
      w_result = r1_word;
      w_single = 1'b0;
      w_double = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_mode  <= 1'b0;
      r1_word  <= '0;
      r1_syn   <= '0;
      r1_par   <= 1'b0;
    end else if (w_s1_en) begin
      r1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r1_mode <= bus.mode;
        r1_word <= bus.mode ? bus.in_data : w_enc_word;
        r1_syn  <= w_syn;
        r1_par  <= w_par;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r2_valid     <= 1'b0;
      r_out_data   <= '0;
      r_err_single <= 1'b0;
      r_err_double <= 1'b0;
    end else if (!w_stall) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r_out_data   <= w_result;
        r_err_single <= w_single;
        r_err_double <= w_double;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else if (w_out_hs) begin
      if (r_err_single && (corr_cnt != 16'hFFFF)) corr_cnt <= corr_cnt + 16'd1;
      if (r_err_double && (dbl_cnt != 16'hFFFF))  dbl_cnt  <= dbl_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
